// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, flag bit positions and the multi-cycle FSM states.
package alu_pkg;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;

  localparam int FLG_OVF   = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_ZERO  = 2;
  localparam int FLG_SIGN  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction
endpackage

// File: rtl/alu_muldiv_unit_if.sv
// Request/response handshake bundle between a requester and the multi-cycle mul/div unit.
interface alu_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       ALUControl;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] resultado;
  logic [3:0]       flagsResult;

  modport master (
    output req_valid, a, b, ALUControl, rsp_ready,
    input  req_ready, rsp_valid, resultado, flagsResult
  );

  modport slave (
    input  req_valid, a, b, ALUControl, rsp_ready,
    output req_ready, rsp_valid, resultado, flagsResult
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of LSB-first shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_mul,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, divisor} : '0);
    shifted = {hi, lo[WIDTH-1]};
    // Explicit compare keeps divide-by-zero yielding all-ones quotient and remainder = dividend.
    ge      = shifted >= {1'b0, divisor};
    diff    = shifted[WIDTH-1:0] - divisor;
    if (is_mul) begin
      next_hi = sum[WIDTH:1];
      next_lo = {sum[0], lo[WIDTH-1:1]};
    end else if (ge) begin
      next_hi = diff;
      next_lo = {lo[WIDTH-2:0], 1'b1};
    end else begin
      next_hi = shifted[WIDTH-1:0];
      next_lo = {lo[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/alu_muldiv_unit.sv
// Multi-cycle MUL/DIV/MOD unit: WIDTH iterations plus one finalize cycle, valid/ready handshake.
module alu_muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  alu_muldiv_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] b_q, hi_q, lo_q, next_hi, next_lo;
  logic [WIDTH-1:0] res_q, res_fin;
  logic [3:0]       flags_q, flags_fin;
  logic             accept, finish, iterate;

  assign bus.req_ready   = (state_q == IDLE) && !rst;
  assign bus.rsp_valid   = (state_q == DONE);
  assign bus.resultado   = res_q;
  assign bus.flagsResult = flags_q;

  assign accept  = bus.req_valid && bus.req_ready;
  assign finish  = (state_q == BUSY) && (cnt_q == LAST);
  assign iterate = (state_q == BUSY) && (cnt_q != LAST);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_mul  (op_q == OP_MUL),
    .hi      (hi_q),
    .lo      (lo_q),
    .divisor (b_q),
    .next_hi (next_hi),
    .next_lo (next_lo)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = op_legal(bus.ALUControl) ? BUSY : DONE;
      BUSY:    if (cnt_q == LAST) state_d = DONE;
      DONE:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flags_fin = '0;
    res_fin   = (op_q == OP_MOD) ? hi_q : lo_q;
    if (op_q == OP_MUL) begin
      flags_fin[FLG_OVF]   = |hi_q;
      flags_fin[FLG_CARRY] = |hi_q;
    end else begin
      flags_fin[FLG_OVF]   = (b_q == '0);
    end
    flags_fin[FLG_ZERO] = (res_fin == '0);
    flags_fin[FLG_SIGN] = res_fin[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) cnt_q <= '0;
      else if (iterate) cnt_q <= cnt_q + CNT_W'(1);
      // Results change only when a response is produced, so they stay put in IDLE and BUSY.
      if (accept && !op_legal(bus.ALUControl)) begin
        res_q              <= '0;
        flags_q            <= '0;
        flags_q[FLG_OVF]   <= 1'b1;
        flags_q[FLG_ZERO]  <= 1'b1;
      end else if (finish) begin
        res_q   <= res_fin;
        flags_q <= flags_fin;
      end
    end
  end

  // Operand/accumulator datapath carries no reset; it is always reloaded at acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= bus.ALUControl;
      b_q  <= bus.b;
      hi_q <= '0;
      lo_q <= bus.a;
    end else if (iterate) begin
      hi_q <= next_hi;
      lo_q <= next_lo;
    end
  end
endmodule

// File: doc/alu_muldiv_unit.md
ALU_MULDIV_UNIT -- requirements
Module: alu_muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have req_valid  input  1  request present.
REQ-005 SHALL have req_ready  output  1  unit can accept a request.
REQ-006 SHALL have a  input  WIDTH  operand A (unsigned).
REQ-007 SHALL have b  input  WIDTH  operand B (unsigned).
REQ-008 SHALL have ALUControl  input  3  op code: 3'b010 MUL, 3'b011 DIV, 3'b100 MOD.
REQ-009 SHALL have rsp_valid  output  1  response present.
REQ-010 SHALL have rsp_ready  input  1  consumer accepts response.
REQ-011 SHALL have resultado  output  WIDTH  result.
REQ-012 SHALL have flagsResult  output  4  [0] overflow, [1] carry, [2] zero, [3] sign.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL assert req_ready only in IDLE; request accepted on an edge with req_valid && req_ready.
REQ-015 SHALL register a, b, ALUControl at acceptance; later input changes have no effect on the running operation.
REQ-016 SHALL, for a legal op, go IDLE->BUSY on acceptance, run exactly WIDTH iteration cycles (iteration counter 0..WIDTH-1), then go BUSY->DONE.
REQ-017 SHALL assert rsp_valid only in DONE; first rsp_valid cycle is WIDTH+1 cycles after the accepting edge.
REQ-018 SHALL hold resultado and flagsResult stable while rsp_valid is high and rsp_ready low.
REQ-019 SHALL go DONE->IDLE on an edge with rsp_valid && rsp_ready; req_ready rises the following cycle (no same-cycle new acceptance).
REQ-020 SHALL compute MUL by shift-add: resultado = low WIDTH bits of a*b; overflow = carry = (high WIDTH bits of 2*WIDTH product != 0).
REQ-021 SHALL compute DIV/MOD by restoring shift-subtract: DIV resultado = a/b, MOD resultado = a%b; carry = 0; overflow = (b == 0).
REQ-022 SHALL, for b == 0, return DIV resultado = all ones, MOD resultado = a, same WIDTH+1 latency.
REQ-023 SHALL set zero = (resultado == 0) and sign = resultado[WIDTH-1] for every op.
REQ-024 SHALL accept an illegal op code, go directly IDLE->DONE, respond after 1 cycle with resultado = 0, flagsResult = 4'b0101.
REQ-025 SHALL keep resultado and flagsResult at their last response value outside DONE.

Reset
REQ-026 SHALL, on rst high, immediately force state IDLE, counter 0, resultado 0, flagsResult 0, rsp_valid 0.
REQ-027 SHALL keep req_ready low while rst is high and high in the first cycle after rst deasserts.
REQ-028 SHALL abandon any BUSY or DONE operation on reset; no response is ever produced for it.

Structure
REQ-029 SHALL take op encodings, flag bit indices and the FSM state enum from shared package alu_pkg, also used by ALUTopLevel.
REQ-030 SHALL place one iteration of the shift-add / shift-subtract datapath in combinational sub-module muldiv_step; FSM, counter and registers stay in alu_muldiv_unit.

Verification
REQ-031 SHALL cover MUL a=5, b=0 -> resultado 0, flags 4'b0100, rsp_valid 33 cycles after accept (WIDTH=32).
REQ-032 SHALL cover DIV a=25, b=5 -> 5, flags 4'b0000; MOD a=30, b=7 -> 2, flags 4'b0000.
REQ-033 SHALL cover MUL a=32'h0001_0000, b=32'h0001_0000 -> 0, flags 4'b0111; MUL a=32'hFFFF_FFFF, b=1 -> 32'hFFFF_FFFF, flags 4'b1000.
REQ-034 SHALL cover DIV a=7, b=0 -> 32'hFFFF_FFFF, flags 4'b1001; MOD a=7, b=0 -> 7, flags 4'b0001.
REQ-035 SHALL cover backpressure: rsp_ready low 10 cycles in DONE -> outputs stable, req_ready low; operand changes during BUSY ignored.
REQ-036 SHALL cover rst pulsed mid-BUSY (iteration 15) -> outputs zero, next request DIV 100/3 -> 33, flags 4'b0000, no stale response.
